// File: rtl/qnigma_crypt_pkg.sv
// Shared types and helpers for the X25519 sequencer.
// Status codes, FSM states, and scalar/u-coordinate preprocessing.
package qnigma_crypt_pkg;

  localparam int unsigned CRYPT_MAX_W = 1024;

  typedef enum logic [1:0] {
    STS_OK   = 2'd0,
    STS_ZERO = 2'd1,
    STS_TMO  = 2'd2,
    STS_LEN  = 2'd3
  } x25519_sts_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_CALC,
    ST_RDREQ,
    ST_READ,
    ST_DONE
  } x25519_st_t;

  // Clamp a little-endian scalar of width w.
  function automatic logic [CRYPT_MAX_W-1:0] clamp_25519(
    input logic [CRYPT_MAX_W-1:0] s,
    input int unsigned            w
  );
    logic [CRYPT_MAX_W-1:0] r;
    r = s;
    r[2:0] = 3'b000;
    if (w > 255) begin
      r[255] = 1'b0;
      r[254] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [CRYPT_MAX_W-1:0] mask_u_25519(
    input logic [CRYPT_MAX_W-1:0] u
  );
    logic [CRYPT_MAX_W-1:0] r;
    r = u;
    r[255] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/qnigma_x25519_ctl.sv
// X25519 request sequencer: clamps inputs, loads u into the ALU, runs
// the ECP core, reads the result back and returns it with a status.
// Ports: req_* request in, rsp_* response out, ecp_* core control,
// ext_wr_* / ext_rd_* ALU word bus. All outputs registered.
module qnigma_x25519_ctl
  import qnigma_crypt_pkg::*;
#(
  parameter int unsigned W         = 256,
  parameter int unsigned IFC_W     = 8,
  parameter int unsigned TMO_TICKS = 2**22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic             req_gen,
  input  logic [W-1:0]     req_scalar,
  input  logic [W-1:0]     req_u,
  output logic             rsp_val,
  input  logic             rsp_rdy,
  output logic [W-1:0]     rsp_dat,
  output logic [1:0]       rsp_sts,
  output logic             ecp_generator,
  output logic [W-1:0]     ecp_scalar,
  output logic             ecp_start,
  input  logic             ecp_ready,
  output logic [IFC_W-1:0] ext_wr_dat,
  output logic             ext_wr_val,
  output logic             ext_wr_sof,
  output logic             ext_rd_req,
  input  logic [IFC_W-1:0] ext_rd_dat,
  input  logic             ext_rd_val,
  input  logic             ext_rd_eof
);

  localparam int unsigned WORDS = W / IFC_W;
  localparam int unsigned CW    = $clog2(WORDS + 1);
  localparam logic [31:0] TMO_L = 32'(TMO_TICKS);

  x25519_st_t  state_q, state_d;
  x25519_sts_t sts_q, sts_d;
  logic             req_rdy_q, req_rdy_d;
  logic             gen_q, gen_d;
  logic [W-1:0]     scalar_q, scalar_d;
  logic [W-1:0]     u_q, u_d;
  logic [W-1:0]     res_q, res_d;
  logic [IFC_W-1:0] wr_dat_q, wr_dat_d;
  logic             wr_val_q, wr_val_d;
  logic             wr_sof_q, wr_sof_d;
  logic             start_q, start_d;
  logic             rd_req_q, rd_req_d;
  logic             rsp_val_q, rsp_val_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      wd_q, wd_d;
  logic [W-1:0]     u_m;
  logic             tmo_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sts_q     <= STS_OK;
      req_rdy_q <= 1'b0;
      gen_q     <= 1'b0;
      scalar_q  <= '0;
      u_q       <= '0;
      res_q     <= '0;
      wr_dat_q  <= '0;
      wr_val_q  <= 1'b0;
      wr_sof_q  <= 1'b0;
      start_q   <= 1'b0;
      rd_req_q  <= 1'b0;
      rsp_val_q <= 1'b0;
      cnt_q     <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      sts_q     <= sts_d;
      req_rdy_q <= req_rdy_d;
      gen_q     <= gen_d;
      scalar_q  <= scalar_d;
      u_q       <= u_d;
      res_q     <= res_d;
      wr_dat_q  <= wr_dat_d;
      wr_val_q  <= wr_val_d;
      wr_sof_q  <= wr_sof_d;
      start_q   <= start_d;
      rd_req_q  <= rd_req_d;
      rsp_val_q <= rsp_val_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
    end
  end

  // wd_q holds cycles elapsed since the START cycle.
  assign tmo_hit = (TMO_TICKS != 0) && (wd_q + 32'd1 >= TMO_L);

  always_comb begin
    state_d   = state_q;
    sts_d     = sts_q;
    gen_d     = gen_q;
    scalar_d  = scalar_q;
    u_d       = u_q;
    res_d     = res_q;
    wr_dat_d  = wr_dat_q;
    wr_val_d  = 1'b0;
    wr_sof_d  = 1'b0;
    start_d   = 1'b0;
    rd_req_d  = 1'b0;
    rsp_val_d = rsp_val_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    u_m = W'(mask_u_25519(CRYPT_MAX_W'(req_u)));
    if (state_q == ST_CALC || state_q == ST_RDREQ ||
        state_q == ST_READ) begin
      if (wd_q != '1) wd_d = wd_q + 32'd1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (req_val && req_rdy_q) begin
          scalar_d = W'(clamp_25519(CRYPT_MAX_W'(req_scalar), W));
          gen_d    = req_gen;
          res_d    = '0;
          cnt_d    = '0;
          if (req_gen) begin
            start_d = 1'b1;
            state_d = ST_START;
          end else begin
            wr_val_d = 1'b1;
            wr_sof_d = 1'b1;
            wr_dat_d = u_m[IFC_W-1:0];
            u_d      = u_m >> IFC_W;
            cnt_d    = CW'(1);
            state_d  = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        // cnt_q = words already placed on the bus
        if (cnt_q == CW'(WORDS)) begin
          start_d = 1'b1;
          state_d = ST_START;
        end else begin
          wr_val_d = 1'b1;
          wr_dat_d = u_q[IFC_W-1:0];
          u_d      = u_q >> IFC_W;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      ST_START: begin
        wd_d    = 32'd1;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        if (ecp_ready) begin
          rd_req_d = 1'b1;
          state_d  = ST_RDREQ;
        end else if (tmo_hit) begin
          rsp_val_d = 1'b1;
          sts_d     = STS_TMO;
          res_d     = '0;
          state_d   = ST_DONE;
        end
      end
      ST_RDREQ: begin
        cnt_d   = '0;
        state_d = ST_READ;
      end
      ST_READ: begin
        if (ext_rd_val) begin
          res_d = (res_q >> IFC_W) | (W'(ext_rd_dat) << (W - IFC_W));
          if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        end
        if (ext_rd_eof) begin
          rsp_val_d = 1'b1;
          state_d   = ST_DONE;
          if (cnt_d != CW'(WORDS)) sts_d = STS_LEN;
          else if (res_d == '0)    sts_d = STS_ZERO;
          else                     sts_d = STS_OK;
        end else if (tmo_hit) begin
          rsp_val_d = 1'b1;
          sts_d     = STS_TMO;
          res_d     = '0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_rdy) begin
          rsp_val_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_rdy_d = (state_d == ST_IDLE);
  end

  assign req_rdy       = req_rdy_q;
  assign rsp_val       = rsp_val_q;
  assign rsp_dat       = res_q;
  assign rsp_sts       = sts_q;
  assign ecp_generator = gen_q;
  assign ecp_scalar    = scalar_q;
  assign ecp_start     = start_q;
  assign ext_wr_dat    = wr_dat_q;
  assign ext_wr_val    = wr_val_q;
  assign ext_wr_sof    = wr_sof_q;
  assign ext_rd_req    = rd_req_q;

endmodule

// File: tb/tb_qnigma_x25519_ctl.sv
// Bench for qnigma_x25519_ctl: stub ALU/ECP driven inline, results
// checked against a field-arithmetic X25519 reference model.
module tb_qnigma_x25519_ctl;

  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;
  localparam int M_OK = 0, M_TMO = 1, M_LEN = 2, M_HOLD = 3, M_RST = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_val, req_rdy, req_gen;
  logic [255:0] req_scalar, req_u;
  logic         rsp_val, rsp_rdy;
  logic [255:0] rsp_dat;
  logic [1:0]   rsp_sts;
  logic         ecp_generator, ecp_start, ecp_ready;
  logic [255:0] ecp_scalar;
  logic [7:0]   ext_wr_dat, ext_rd_dat;
  logic         ext_wr_val, ext_wr_sof, ext_rd_req;
  logic         ext_rd_val, ext_rd_eof;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  qnigma_x25519_ctl #(.W(256), .IFC_W(8), .TMO_TICKS(1000)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_gen(req_gen),
    .req_scalar(req_scalar), .req_u(req_u),
    .rsp_val(rsp_val), .rsp_rdy(rsp_rdy),
    .rsp_dat(rsp_dat), .rsp_sts(rsp_sts),
    .ecp_generator(ecp_generator), .ecp_scalar(ecp_scalar),
    .ecp_start(ecp_start), .ecp_ready(ecp_ready),
    .ext_wr_dat(ext_wr_dat), .ext_wr_val(ext_wr_val),
    .ext_wr_sof(ext_wr_sof), .ext_rd_req(ext_rd_req),
    .ext_rd_dat(ext_rd_dat), .ext_rd_val(ext_rd_val),
    .ext_rd_eof(ext_rd_eof)
  );

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] fadd(input logic [255:0] a,
                                        input logic [255:0] b);
    logic [256:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a,
                                        input logic [255:0] b);
    logic [256:0] s;
    s = ({1'b0, a} + {1'b0, P} - {1'b0, b}) % {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fmul(input logic [255:0] a,
                                        input logic [255:0] b);
    logic [511:0] pr;
    pr = ({256'd0, a} * {256'd0, b}) % {256'd0, P};
    return pr[255:0];
  endfunction

  function automatic logic [255:0] finv(input logic [255:0] a);
    logic [255:0] r, e;
    r = 256'd1;
    e = P - 256'd2;
    for (int i = 254; i >= 0; i--) begin
      r = fmul(r, r);
      if (e[i]) r = fmul(r, a);
    end
    return r;
  endfunction

  // Montgomery ladder; k is used as given (bits 254..0).
  function automatic logic [255:0] x25519(input logic [255:0] k,
                                          input logic [255:0] u);
    logic [255:0] x1, x2, z2, x3, z3, a, aa, b, bb, e, c, d, da, cb, t;
    bit sw, kt;
    x1 = fadd(u, 256'd0);
    x2 = 256'd1; z2 = 256'd0; x3 = x1; z3 = 256'd1; sw = 1'b0;
    for (int i = 254; i >= 0; i--) begin
      kt = k[i];
      sw = sw ^ kt;
      if (sw) begin
        t = x2; x2 = x3; x3 = t;
        t = z2; z2 = z3; z3 = t;
      end
      sw = kt;
      a  = fadd(x2, z2); aa = fmul(a, a);
      b  = fsub(x2, z2); bb = fmul(b, b);
      e  = fsub(aa, bb);
      c  = fadd(x3, z3); d = fsub(x3, z3);
      da = fmul(d, a);   cb = fmul(c, b);
      t  = fadd(da, cb); x3 = fmul(t, t);
      t  = fsub(da, cb); z3 = fmul(x1, fmul(t, t));
      x2 = fmul(aa, bb);
      z2 = fmul(e, fadd(aa, fmul(256'd121665, e)));
    end
    if (sw) begin
      t = x2; x2 = x3; x3 = t;
      t = z2; z2 = z3; z3 = t;
    end
    return fmul(x2, finv(z2));
  endfunction

  function automatic logic [255:0] clamp_ref(input logic [255:0] k);
    return (k & ~256'd7 & ~(256'd1 << 255)) | (256'd1 << 254);
  endfunction

  // RFC hex string (first byte leftmost) -> byte 0 at bits [7:0]
  function automatic logic [255:0] le(input logic [255:0] h);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = h[8*(31-i) +: 8];
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] all_out();
    return 256'(|{req_rdy, rsp_val, rsp_dat, rsp_sts, ecp_generator,
                   ecp_scalar, ecp_start, ext_wr_dat, ext_wr_val,
                   ext_wr_sof, ext_rd_req});
  endfunction

  task automatic do_req(input string nm, input logic [255:0] sc,
                        input logic [255:0] u, input bit gen,
                        input int mode, input bit has_rfc,
                        input logic [255:0] rfc);
    logic [255:0] exp_sc, exp_u, got_u, stub_res, exp_res, held;
    int nwr, cyc, nw;
    bit sof_ok, stable;
    exp_sc = clamp_ref(sc);
    exp_u  = u & ~(256'd1 << 255);
    chk({nm, ":rdy"}, 256'(req_rdy), 256'd1);
    req_val = 1'b1; req_gen = gen; req_scalar = sc; req_u = u;
    @(negedge clk);
    req_val = 1'b0; req_gen = ~gen;
    req_scalar = rnd256(); req_u = rnd256();
    nwr = 0; cyc = 0; got_u = '0; sof_ok = 1'b1;
    while (ecp_start !== 1'b1 && cyc < 100) begin
      if (ext_wr_val === 1'b1) begin
        if (nwr < 32) got_u[nwr*8 +: 8] = ext_wr_dat;
        if (ext_wr_sof !== (nwr == 0)) sof_ok = 1'b0;
        nwr++;
      end
      @(negedge clk);
      cyc++;
    end
    chk({nm, ":start_lat"}, 256'(cyc), gen ? 256'd0 : 256'd32);
    chk({nm, ":nwr"}, 256'(nwr), gen ? 256'd0 : 256'd32);
    if (!gen) begin
      chk({nm, ":wr_u"}, got_u, exp_u);
      chk({nm, ":sof"}, 256'(sof_ok), 256'd1);
    end
    chk({nm, ":scalar"}, ecp_scalar, exp_sc);
    chk({nm, ":gen"}, 256'(ecp_generator), 256'(gen));
    if (mode == M_TMO) begin
      cyc = 0;
      while (rsp_val !== 1'b1 && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      chk({nm, ":tmo_lat"}, 256'(cyc), 256'd1000);
      chk({nm, ":tmo_sts"}, 256'(rsp_sts), 256'd2);
      chk({nm, ":tmo_dat"}, rsp_dat, 256'd0);
      rsp_rdy = 1'b1;
      @(negedge clk);
      rsp_rdy = 1'b0;
      chk({nm, ":idle"}, 256'({rsp_val, req_rdy}), 256'd1);
      return;
    end
    if (mode == M_RST) begin
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk({nm, ":rst_outs"}, all_out(), 256'd0);
      rst = 1'b0;
      @(negedge clk);
      chk({nm, ":rst_rdy"}, 256'({rsp_val, req_rdy}), 256'd1);
      repeat (3) @(negedge clk);
      chk({nm, ":no_rsp"}, 256'(rsp_val), 256'd0);
      return;
    end
    stub_res = x25519(ecp_scalar, gen ? 256'd9 : got_u);
    nw = $urandom_range(1, 4);
    repeat (nw) begin
      ext_rd_val = 1'b1;
      ext_rd_dat = 8'($urandom);
      @(negedge clk);
    end
    ext_rd_val = 1'b0;
    ecp_ready = 1'b1;
    @(negedge clk);
    ecp_ready = 1'b0;
    chk({nm, ":rd_req"}, 256'(ext_rd_req), 256'd1);
    @(negedge clk);
    nw = (mode == M_LEN) ? 31 : 32;
    for (int i = 0; i < nw; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        ext_rd_val = 1'b0;
        @(negedge clk);
      end
      ext_rd_val = 1'b1;
      ext_rd_dat = stub_res[8*i +: 8];
      ext_rd_eof = (i == nw - 1);
      @(negedge clk);
    end
    ext_rd_val = 1'b0;
    ext_rd_eof = 1'b0;
    chk({nm, ":rsp_lat"}, 256'(rsp_val), 256'd1);
    exp_res = x25519(exp_sc, gen ? 256'd9 : exp_u);
    if (mode == M_LEN) begin
      chk({nm, ":len_sts"}, 256'(rsp_sts), 256'd3);
    end else begin
      chk({nm, ":sts"}, 256'(rsp_sts), (exp_res == 0) ? 256'd1 : 256'd0);
      chk({nm, ":dat"}, rsp_dat, exp_res);
      if (has_rfc) chk({nm, ":rfc"}, rsp_dat, rfc);
    end
    if (mode == M_HOLD) begin
      held = rsp_dat;
      stable = 1'b1;
      repeat (50) begin
        @(negedge clk);
        if (rsp_val !== 1'b1 || rsp_dat !== held || req_rdy !== 1'b0)
          stable = 1'b0;
      end
      chk({nm, ":hold"}, 256'(stable), 256'd1);
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    chk({nm, ":idle"}, 256'({rsp_val, req_rdy}), 256'd1);
  endtask

  logic [255:0] a_priv, a_pub, b_pub, shared;

  initial begin
    a_priv = le(256'h77076d0a7318a57d3c16c17251b26645df4c2f87ebc0992ab177fba51db92c2a);
    a_pub  = le(256'h8520f0098930a754748b7ddcb43ef75a0dbf3a0d26381af4eba4a98eaa9b4e6a);
    b_pub  = le(256'hde9edb7d7b7dc1b4d35b61c2ece435373f8343c85b78674dadfc7e146f882b4f);
    shared = le(256'h4a5d9d5ba4ce2de1728e3bf480350f25e07e21c947d19e3376f09b3c1e161742);
    rst = 1'b1;
    req_val = 1'b0; req_gen = 1'b0; req_scalar = '0; req_u = '0;
    rsp_rdy = 1'b0; ecp_ready = 1'b0;
    ext_rd_dat = '0; ext_rd_val = 1'b0; ext_rd_eof = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_out(), 256'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rdy", 256'(req_rdy), 256'd1);

    do_req("gen_alice", a_priv, rnd256(), 1'b1, M_OK, 1'b1, a_pub);
    do_req("pt_alice_bob", a_priv, b_pub, 1'b0, M_OK, 1'b1, shared);
    do_req("u_zero", rnd256(), 256'd0, 1'b0, M_OK, 1'b1, 256'd0);
    do_req("rand_hold", rnd256(), rnd256(), 1'b0, M_HOLD, 1'b0, '0);
    do_req("rand_gen", rnd256(), rnd256(), 1'b1, M_OK, 1'b0, '0);
    do_req("tmo", rnd256(), rnd256(), 1'($urandom), M_TMO, 1'b0, '0);
    do_req("short", rnd256(), rnd256(), 1'b0, M_LEN, 1'b0, '0);
    do_req("rst_calc", rnd256(), rnd256(), 1'b0, M_RST, 1'b0, '0);
    do_req("after_rst", rnd256(), rnd256(), 1'b0, M_OK, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
